fetch_stage: RTL and testbench

- IF stage of the P5 five-stage MIPS pipeline.
- Owns the PC register and a request/acknowledge handshake to instruction memory.
- Drives the IF/ID pipeline register, whose `id_instr` feeds the ID-stage instruction decoder.
- Architectural branch delay slot: a redirect never squashes the instruction already being fetched.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_skid_buf.sv | 32 +++
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the P5 IF stage.
//   DEF_RESET_PC / DEF_NOP_WORD : defaults for the fetch_stage parameters
//   fstate_e                    : fetch FSM encoding (FS_REQ, FS_HOLD)
//   fetch_word_t                : {instr, pc} pair carried by the skid buffer
package fetch_stage_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic {
    FS_REQ  = 1'b0,
    FS_HOLD = 1'b1
  } fstate_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {instr,pc} holding register. Catches a word acked while the
// pipeline is stalled so it never has to be refetched.
//   clk, reset_n : clock, async active-low reset
//   load         : capture din (wins over unload)
//   unload       : release the entry
//   din / dout   : word in / held word
//   full         : entry valid
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        unload,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        full
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the P5 five-stage MIPS pipeline: PC register, imem
// request/ack handshake, IF/ID pipeline register. Branch delay slot is
// architectural: a redirect never squashes the word already in fetch.
//   clk, reset_n              : clock, async active-low reset
//   imem_req/addr/ack/rdata   : instruction memory handshake
//   stall                     : hazard unit freeze of PC and IF/ID
//   redirect_valid/pc         : taken branch/jump resolved in ID
//   id_valid/instr/pc/pc8     : IF/ID register (pc8 is the jal link)
// Optional: define FETCH_ADEL_EN to add id_exc_adel (misaligned fetch
// raises an address-error bubble instead of issuing a request).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8
`ifdef FETCH_ADEL_EN
  ,
  output logic        id_exc_adel
`endif
);

  fstate_e     state_q, state_d;
  logic        run_q;          // low for the first cycle after reset release
  logic [31:0] pc_q, pend_pc, npc;
  logic        redirect_pend, redir_now;
  logic        advance, ifid_load, valid_d;
  logic        skid_load, skid_unload, skid_full;
  fetch_word_t ifid_d, skid_dout;
  logic        active;

  assign active = run_q && (state_q == FS_REQ);

`ifdef FETCH_ADEL_EN
  logic adel, adel_d;
  assign adel      = |pc_q[1:0];
  assign imem_req  = active && !adel;
  assign imem_addr = pc_q;
`else
  assign imem_req  = active;
  assign imem_addr = {pc_q[31:2], 2'b00};
`endif

  // A branch leaving ID in the same cycle its delay slot is accepted must
  // still steer that slot's successor, so the live redirect bypasses pend.
  assign redir_now = redirect_valid && !stall;
  assign npc = redir_now     ? redirect_pc :
               redirect_pend ? pend_pc     : pc_q + 32'd4;

  assign id_pc8 = id_pc + 32'd8;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (skid_load),
    .unload (skid_unload),
    .din    ('{instr: imem_rdata, pc: pc_q}),
    .dout   (skid_dout),
    .full   (skid_full)
  );

  always_comb begin
    state_d     = state_q;
    advance     = 1'b0;
    ifid_load   = 1'b0;
    valid_d     = 1'b0;
    ifid_d      = '{instr: NOP_WORD, pc: id_pc};
    skid_load   = 1'b0;
    skid_unload = 1'b0;
`ifdef FETCH_ADEL_EN
    adel_d      = 1'b0;
`endif
    case (state_q)
      FS_REQ: if (run_q) begin
`ifdef FETCH_ADEL_EN
        if (adel) begin
          if (!stall) begin
            ifid_load = 1'b1;
            valid_d   = 1'b1;
            ifid_d    = '{instr: NOP_WORD, pc: pc_q};
            adel_d    = 1'b1;
            advance   = 1'b1;
          end
        end else
`endif
        if (imem_ack && !stall) begin
          ifid_load = 1'b1;
          valid_d   = 1'b1;
          ifid_d    = '{instr: imem_rdata, pc: pc_q};
          advance   = 1'b1;
        end else if (imem_ack) begin
          skid_load = 1'b1;
          state_d   = FS_HOLD;
        end else if (!stall) begin
          ifid_load = 1'b1;     // bubble; id_pc left as is
        end
      end
      FS_HOLD: if (!stall) begin
        ifid_load   = 1'b1;
        valid_d     = skid_full;
        ifid_d      = skid_dout;
        skid_unload = 1'b1;
        advance     = 1'b1;
        state_d     = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FS_REQ;
      run_q         <= 1'b0;
      pc_q          <= RESET_PC;
      redirect_pend <= 1'b0;
      pend_pc       <= RESET_PC;
      id_valid      <= 1'b0;
      id_instr      <= NOP_WORD;
      id_pc         <= RESET_PC;
`ifdef FETCH_ADEL_EN
      id_exc_adel   <= 1'b0;
`endif
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (advance) pc_q <= npc;
      // Advancing consumes whichever target npc used; otherwise remember the
      // newest redirect until the delay slot is accepted.
      if (advance) begin
        redirect_pend <= 1'b0;
      end else if (redir_now) begin
        redirect_pend <= 1'b1;
        pend_pc       <= redirect_pc;
      end
      if (ifid_load) begin
        id_valid    <= valid_d;
        id_instr    <= ifid_d.instr;
        id_pc       <= ifid_d.pc;
`ifdef FETCH_ADEL_EN
        id_exc_adel <= adel_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc8;
`ifdef FETCH_ADEL_EN
  logic        id_exc_adel;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc8        (id_pc8)
`ifdef FETCH_ADEL_EN
    ,
    .id_exc_adel   (id_exc_adel)
`endif
  );

  // Memory image: word at 0x3000 is 0x3c01_0001, then +1 per word.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h3c01_0001 + ((a - 32'h0000_3000) >> 2);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1 ({tag, "_req"},   imem_req, 1'b0);
    chk1 ({tag, "_valid"}, id_valid, 1'b0);
    chk32({tag, "_instr"}, id_instr, 32'h0);
    chk32({tag, "_pc"},    id_pc,    32'h3000);
    chk32({tag, "_pc8"},   id_pc8,   32'h3008);
  endtask

  // Per-cycle directed vector: inputs, then req/addr seen during the cycle
  // and IF/ID content after the clock edge.
  typedef struct packed {
    logic        stall;
    logic        ack;
    logic        rv;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  // Reference-model state for the random phase
  logic [31:0] exp_next, tgt;
  logic        ds_next, cur_is_ds;
  logic        o_valid, o_req, p_req, p_ack;
  logic [31:0] o_instr, o_pc, o_addr, p_addr;
  int          delivered;

  initial begin
    //            stall  ack    rv     rpc           req    addr          valid  pc
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3000,     1'b1, 32'h3000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3004,     1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3004,     1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3004,     1'b1, 32'h3004};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3008,     1'b1, 32'h3008};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h3100,     1'b1, 32'h300C,     1'b1, 32'h300C};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3100,     1'b1, 32'h3100};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3104,     1'b1, 32'h3100};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h3100};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h3104};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3108,     1'b1, 32'h3108};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h3300,     1'b1, 32'h310C,     1'b1, 32'h3108};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h3200,     1'b0, 32'h0,        1'b1, 32'h310C};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3200,     1'b1, 32'h3200};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3204,     1'b1, 32'h3204};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 32'h3500,     1'b1, 32'h3208,     1'b1, 32'h3204};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3208,     1'b1, 32'h3208};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h320C,     1'b1, 32'h320C};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h3210,    1'b1, 32'h3210};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0};

    // ---- reset values, then release
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    #1 chk1("first_cycle_noreq", imem_req, 1'b0);

    // ---- directed table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk1($sformatf("v%0d_req", i), imem_req, tbl[i].ereq);
      if (tbl[i].ereq) chk32($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
      stall          = tbl[i].stall;
      imem_ack       = tbl[i].ack;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      imem_rdata     = memw(imem_addr);
      @(posedge clk);
      #1;
      chk1($sformatf("v%0d_valid", i), id_valid, tbl[i].evalid);
      chk32($sformatf("v%0d_instr", i), id_instr, tbl[i].evalid ? memw(tbl[i].epc) : 32'h0);
      if (tbl[i].evalid) begin
        chk32($sformatf("v%0d_pc", i),  id_pc,  tbl[i].epc);
        chk32($sformatf("v%0d_pc8", i), id_pc8, tbl[i].epc + 32'd8);
      end
    end

    // ---- reset mid-request with a late ack
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    chk1("mid_req_pending", imem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 chk_reset_vals("late_ack");
    @(negedge clk);
    imem_ack = 1'b0;
    reset_n  = 1'b1;
    #1 chk1("post_rst_noreq", imem_req, 1'b0);
    @(negedge clk);
    chk1("post_rst_req", imem_req, 1'b1);
    chk32("post_rst_addr", imem_addr, 32'h3000);
    imem_ack = 1'b1; imem_rdata = memw(imem_addr);
    @(posedge clk);
    #1;
    chk1("post_rst_valid", id_valid, 1'b1);
    chk32("post_rst_pc", id_pc, 32'h3000);
    chk32("post_rst_instr", id_instr, memw(32'h3000));

    // ---- randomized run against the program-order model
    @(negedge clk);
    imem_ack = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    exp_next  = 32'h3000;
    tgt       = '0;
    ds_next   = 1'b0;
    cur_is_ds = 1'b0;
    p_req     = 1'b0;
    p_ack     = 1'b0;
    p_addr    = '0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      o_valid = id_valid; o_instr = id_instr; o_pc = id_pc;
      o_req = imem_req;   o_addr = imem_addr;
      // An unanswered request must persist unchanged.
      if (p_req && !p_ack) begin
        chk1("rnd_req_hold", o_req, 1'b1);
        chk32("rnd_addr_hold", o_addr, p_addr);
      end
      stall    = ($urandom_range(0, 4) == 0);
      imem_ack = o_req && ($urandom_range(0, 3) != 0);
      imem_rdata = imem_ack ? memw(o_addr) : $urandom;
      if (stall) begin
        // noise: must be ignored while stalled
        redirect_valid = ($urandom_range(0, 3) == 0);
        redirect_pc    = 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
      end else begin
        redirect_valid = o_valid && !cur_is_ds && ($urandom_range(0, 4) == 0);
        redirect_pc    = 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
      end
      @(posedge clk);
      #1;
      if (redirect_valid && !stall) begin
        ds_next = 1'b1;
        tgt     = redirect_pc;
      end
      if (stall) begin
        chk1("rnd_frz_valid", id_valid, o_valid);
        chk32("rnd_frz_instr", id_instr, o_instr);
        chk32("rnd_frz_pc", id_pc, o_pc);
      end else if (id_valid) begin
        chk32("rnd_pc", id_pc, exp_next);
        chk32("rnd_instr", id_instr, memw(id_pc));
        chk32("rnd_pc8", id_pc8, id_pc + 32'd8);
`ifdef FETCH_ADEL_EN
        chk1("rnd_adel", id_exc_adel, 1'b0);
`endif
        delivered++;
        cur_is_ds = ds_next;
        exp_next  = ds_next ? tgt : id_pc + 32'd4;
        ds_next   = 1'b0;
      end else begin
        chk32("rnd_bubble", id_instr, 32'h0);
        cur_is_ds = 1'b0;
      end
      p_req  = o_req;
      p_ack  = imem_ack;
      p_addr = o_addr;
      @(negedge clk);
    end
    chk1("rnd_progress", delivered > 500, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
